// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces three raw coin sensors, rejects
// ambiguous multi-sensor hits, and queues accepted coins for the vending FSM.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   sens_nickel/dime/quarter  raw asynchronous sensor lines, high = coin
//   coin_ready         downstream accepts the head coin this cycle
//   coin               head coin code (NICKEL=001, DIME=010, QUARTER=101), 000 when empty
//   coin_valid         queue non-empty
//   reject             one-cycle pulse: coin discarded (ambiguous or overflow)
//   fifo_count         entries currently queued
//   overflow_err       sticky overflow flag, cleared only by reset
module coin_acceptor #(
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sens_nickel,
  input  logic       sens_dime,
  input  logic       sens_quarter,
  input  logic       coin_ready,
  output logic [2:0] coin,
  output logic       coin_valid,
  output logic       reject,
  output logic [3:0] fifo_count,
  output logic       overflow_err
);

  localparam int unsigned NCH = 3;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] CODE_NICKEL  = 3'b001;
  localparam logic [2:0] CODE_DIME    = 3'b010;
  localparam logic [2:0] CODE_QUARTER = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILTER = 2'd1,
    ST_HELD   = 2'd2
  } ch_state_e;

  // Two-flop synchronisers; bit 0 nickel, bit 1 dime, bit 2 quarter.
  logic [NCH-1:0] raw_c;
  logic [NCH-1:0] sync1_q, sync2_q;

  assign raw_c = {sens_quarter, sens_dime, sens_nickel};

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce FSM state registers.
  ch_state_e      state_q [NCH];
  ch_state_e      state_d [NCH];
  logic [2:0]     cnt_q   [NCH];
  logic [2:0]     cnt_d   [NCH];
  logic [NCH-1:0] event_c;

  // Reset into HELD so a sensor stuck high through reset is not counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_HELD;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Debounce next-state: one event per insertion, fired on the DEBOUNCE-th high sample.
  always_comb begin
    event_c = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) begin
            state_d[i] = ST_FILTER;
            cnt_d[i]   = 3'd1;
          end
        end
        ST_FILTER: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == 3'(DEBOUNCE - 1)) begin
            event_c[i] = 1'b1;
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 3'd1;
          end
        end
        ST_HELD: begin
          if (sync2_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == 3'(DEBOUNCE - 1)) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 3'd1;
          end
        end
        default: begin
          state_d[i] = ST_HELD;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Arbitration: exactly one event pushes its code, two or more are ambiguous.
  logic       single_ev_c;
  logic       multi_ev_c;
  logic [2:0] push_code_c;

  always_comb begin
    single_ev_c = 1'b0;
    push_code_c = 3'b000;
    case (event_c)
      3'b001: begin single_ev_c = 1'b1; push_code_c = CODE_NICKEL;  end
      3'b010: begin single_ev_c = 1'b1; push_code_c = CODE_DIME;    end
      3'b100: begin single_ev_c = 1'b1; push_code_c = CODE_QUARTER; end
      default: begin single_ev_c = 1'b0; push_code_c = 3'b000; end
    endcase
    multi_ev_c = (event_c != '0) && !single_ev_c;
  end

  // Coin queue: circular buffer with a separate occupancy count.
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]    count_q, count_d;
  logic          reject_q, overflow_q;
  logic          pop_c, full_c, do_push_c, ovf_c;

  assign pop_c     = (count_q != 4'd0) && coin_ready;
  assign full_c    = (count_q == 4'(FIFO_DEPTH));
  // A pop on the same edge frees the slot, so a full queue can still accept.
  assign do_push_c = single_ev_c && (!full_c || pop_c);
  assign ovf_c     = single_ev_c && full_c && !pop_c;

  always_comb begin
    count_d = count_q;
    if (do_push_c && !pop_c) begin
      count_d = count_q + 4'd1;
    end else if (!do_push_c && pop_c) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= push_code_c;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q    <= count_d;
      reject_q   <= multi_ev_c | ovf_c;
      overflow_q <= overflow_q | ovf_c;
    end
  end

  // Outputs come straight from registers; the head mux only selects stored state.
  assign coin_valid   = (count_q != 4'd0);
  assign coin         = coin_valid ? mem_q[rd_ptr_q] : 3'b000;
  assign reject       = reject_q;
  assign fifo_count   = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor (DEBOUNCE=4, FIFO_DEPTH=4).
module tb_coin_acceptor;

  logic       clock;
  logic       reset;
  logic       sens_nickel, sens_dime, sens_quarter;
  logic       coin_ready;
  logic [2:0] coin;
  logic       coin_valid;
  logic       reject;
  logic [3:0] fifo_count;
  logic       overflow_err;

  coin_acceptor #(.DEBOUNCE(4), .FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .sens_nickel (sens_nickel),
    .sens_dime   (sens_dime),
    .sens_quarter(sens_quarter),
    .coin_ready  (coin_ready),
    .coin        (coin),
    .coin_valid  (coin_valid),
    .reject      (reject),
    .fifo_count  (fifo_count),
    .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int rej_seen = 0;
  logic [2:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every handshake must match the oldest expected coin.
  always @(negedge clock) begin
    if (!reset && coin_valid && coin_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got coin %b, required no coin (t=%0t)", coin, $time);
      end else begin
        chk("pop_coin", 32'(coin), 32'(sb.pop_front()));
      end
    end
    if (reject) rej_seen++;
  end

  // Advance one cycle; inputs and samples sit 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_sens(input logic [2:0] mask);
    sens_nickel  = mask[0];
    sens_dime    = mask[1];
    sens_quarter = mask[2];
  endtask

  task automatic insert(input logic [2:0] mask, input int hi, input int lo);
    set_sens(mask);
    repeat (hi) step();
    set_sens(3'b000);
    repeat (lo) step();
  endtask

  task automatic drain(input string name);
    int k;
    coin_ready = 1'b1;
    k = 0;
    while (fifo_count != 4'd0 && k < 30) begin
      step();
      k++;
    end
    chk({name, "_drained"}, 32'(fifo_count), 32'd0);
  endtask

  typedef struct {
    logic [2:0] mask;
    int         hi;
    logic [2:0] exp_code;
    int         exp_rej;
  } vec_t;

  vec_t vecs[9];
  int   rej0;

  initial begin
    vecs[0] = '{mask: 3'b001, hi: 10, exp_code: 3'b001, exp_rej: 0};
    vecs[1] = '{mask: 3'b010, hi: 4,  exp_code: 3'b010, exp_rej: 0};
    vecs[2] = '{mask: 3'b100, hi: 6,  exp_code: 3'b101, exp_rej: 0};
    vecs[3] = '{mask: 3'b010, hi: 3,  exp_code: 3'b000, exp_rej: 0};
    vecs[4] = '{mask: 3'b001, hi: 1,  exp_code: 3'b000, exp_rej: 0};
    vecs[5] = '{mask: 3'b011, hi: 6,  exp_code: 3'b000, exp_rej: 1};
    vecs[6] = '{mask: 3'b111, hi: 6,  exp_code: 3'b000, exp_rej: 1};
    vecs[7] = '{mask: 3'b110, hi: 5,  exp_code: 3'b000, exp_rej: 1};
    vecs[8] = '{mask: 3'b100, hi: 4,  exp_code: 3'b101, exp_rej: 0};

    reset      = 1'b1;
    coin_ready = 1'b0;
    set_sens(3'b000);

    // Reset state
    repeat (3) step();
    chk("rst_coin",   32'(coin), 32'd0);
    chk("rst_valid",  32'(coin_valid), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    chk("rst_count",  32'(fifo_count), 32'd0);
    chk("rst_ovf",    32'(overflow_err), 32'd0);
    reset = 1'b0;
    repeat (8) step();

    // Clean quarter: exact latency, single push while held high
    sb.push_back(3'b101);
    set_sens(3'b100);
    repeat (5) step();
    chk("cq_valid_early", 32'(coin_valid), 32'd0);
    chk("cq_coin_early",  32'(coin), 32'd0);
    step();
    chk("cq_valid", 32'(coin_valid), 32'd1);
    chk("cq_coin",  32'(coin), 32'b101);
    chk("cq_count", 32'(fifo_count), 32'd1);
    repeat (4) step();
    set_sens(3'b000);
    repeat (10) step();
    chk("cq_count_hold", 32'(fifo_count), 32'd1);
    coin_ready = 1'b1;
    repeat (2) step();
    chk("cq_count_pop", 32'(fifo_count), 32'd0);
    chk("cq_sb_empty", 32'(sb.size()), 32'd0);

    // Table-driven insertions with downstream always ready
    for (int i = 0; i < 9; i++) begin
      rej0 = rej_seen;
      if (vecs[i].exp_code != 3'b000) sb.push_back(vecs[i].exp_code);
      insert(vecs[i].mask, vecs[i].hi, 10);
      chk($sformatf("vec%0d_reject", i), 32'(rej_seen - rej0), 32'(vecs[i].exp_rej));
      chk($sformatf("vec%0d_sb_empty", i), 32'(sb.size()), 32'd0);
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'd0);
    end

    // Ambiguous: reject pulse timing, then a lone nickel is accepted
    coin_ready = 1'b0;
    rej0 = rej_seen;
    set_sens(3'b011);
    repeat (5) step();
    chk("amb_reject_early", 32'(reject), 32'd0);
    step();
    chk("amb_reject", 32'(reject), 32'd1);
    chk("amb_valid",  32'(coin_valid), 32'd0);
    chk("amb_count",  32'(fifo_count), 32'd0);
    step();
    chk("amb_reject_end", 32'(reject), 32'd0);
    set_sens(3'b000);
    repeat (10) step();
    chk("amb_reject_count", 32'(rej_seen - rej0), 32'd1);
    sb.push_back(3'b001);
    insert(3'b001, 5, 10);
    chk("amb_nickel_count", 32'(fifo_count), 32'd1);
    chk("amb_nickel_coin",  32'(coin), 32'b001);
    drain("amb");

    // Handshake/order: three coins queued, then drained back-to-back
    coin_ready = 1'b0;
    sb.push_back(3'b001); insert(3'b001, 5, 10);
    sb.push_back(3'b010); insert(3'b010, 5, 10);
    sb.push_back(3'b101); insert(3'b100, 5, 10);
    chk("hs_count3", 32'(fifo_count), 32'd3);
    coin_ready = 1'b1;
    chk("hs_coin0", 32'(coin), 32'b001);
    step();
    chk("hs_coin1", 32'(coin), 32'b010);
    chk("hs_count2", 32'(fifo_count), 32'd2);
    step();
    chk("hs_coin2", 32'(coin), 32'b101);
    chk("hs_count1", 32'(fifo_count), 32'd1);
    step();
    chk("hs_coin_none", 32'(coin), 32'b000);
    chk("hs_valid0", 32'(coin_valid), 32'd0);
    chk("hs_count0", 32'(fifo_count), 32'd0);

    // Overflow: fifth nickel dropped, then simultaneous push and pop while full
    coin_ready = 1'b0;
    rej0 = rej_seen;
    for (int n = 0; n < 5; n++) begin
      if (n < 4) sb.push_back(3'b001);
      insert(3'b001, 5, 10);
    end
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_reject_count", 32'(rej_seen - rej0), 32'd1);
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    rej0 = rej_seen;
    sb.push_back(3'b001);
    set_sens(3'b001);
    repeat (5) step();
    coin_ready = 1'b1;
    step();
    coin_ready = 1'b0;
    chk("ovf_pp_count", 32'(fifo_count), 32'd4);
    set_sens(3'b000);
    repeat (10) step();
    chk("ovf_pp_reject", 32'(rej_seen - rej0), 32'd0);
    chk("ovf_flag_sticky", 32'(overflow_err), 32'd1);
    drain("ovf");
    chk("ovf_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-operation with a quarter held high through reset
    coin_ready = 1'b0;
    sb.push_back(3'b001); insert(3'b001, 5, 10);
    sb.push_back(3'b010); insert(3'b010, 5, 10);
    chk("rm_count_pre", 32'(fifo_count), 32'd2);
    set_sens(3'b100);
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    sb.delete();
    chk("rm_count",  32'(fifo_count), 32'd0);
    chk("rm_valid",  32'(coin_valid), 32'd0);
    chk("rm_coin",   32'(coin), 32'd0);
    chk("rm_ovf",    32'(overflow_err), 32'd0);
    chk("rm_reject", 32'(reject), 32'd0);
    reset = 1'b0;
    coin_ready = 1'b1;
    rej0 = rej_seen;
    repeat (20) step();
    chk("rm_no_phantom", 32'(fifo_count), 32'd0);
    chk("rm_no_reject", 32'(rej_seen - rej0), 32'd0);
    set_sens(3'b000);
    repeat (10) step();
    sb.push_back(3'b101);
    insert(3'b100, 5, 10);
    chk("rm_quarter_sb_empty", 32'(sb.size()), 32'd0);
    chk("rm_quarter_count", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
